// File: rtl/scrolling_background_if.sv
// Pixel bus between the video timing generator (master) and the background
// painter (slave).
//
// Protocol: there is no backpressure. The master presents a valid pixel
// coordinate every clock; the slave returns that pixel's background colour and
// border flags exactly one clock later. startOfFrame and flash_trigger are
// single-cycle pulses qualified only by the clock. The dbg_* signals expose
// internal state for observation and carry no protocol meaning.
interface scrolling_background_if #(
    parameter int PIXEL_WIDTH = 11,
    parameter int RGB_WIDTH   = 8
);
    logic [PIXEL_WIDTH-1:0] pixelX;
    logic [PIXEL_WIDTH-1:0] pixelY;
    logic                   startOfFrame;
    logic                   scroll_enable;
    logic                   flash_trigger;
    logic [RGB_WIDTH-1:0]   background_RGB;
    logic [1:0]             boardersDrawReq;
    logic                   flash_active;
    logic                   dbg_flash_state;
    logic [PIXEL_WIDTH-1:0] dbg_scroll_offset;

    modport master (
        output pixelX, pixelY, startOfFrame, scroll_enable, flash_trigger,
        input  background_RGB, boardersDrawReq, flash_active,
        input  dbg_flash_state, dbg_scroll_offset
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, scroll_enable, flash_trigger,
        output background_RGB, boardersDrawReq, flash_active,
        output dbg_flash_state, dbg_scroll_offset
    );
endinterface

// File: rtl/scrolling_background.sv
// Background painter for the space-invaders video pipeline: zone boundary
// lines, a frame-timed border flash, and (optionally) a vertically scrolling
// pseudo-random starfield. Colour and border flags are registered, one clock
// after the pixel coordinate.
//
// Optional feature macro: BACKGROUND_STARFIELD_EN. When undefined the star term
// is constant 0, the scroll state is absent and scroll_enable is ignored.
module scrolling_background #(
    parameter int RGB_WIDTH              = 8,
    parameter int PIXEL_WIDTH            = 11,
    parameter int X_FRAME_SIZE           = 639,
    parameter int Y_FRAME_SIZE           = 479,
    parameter int MOVEMENT_ZONE_OFFSET   = 20,
    parameter int STATISTICS_ZONE_OFFSET = 20,
    parameter int PLAYER_ZONE_Y          = 310,
    parameter logic [RGB_WIDTH-1:0] BACKGROUND_COLOR        = 8'h00,
    parameter logic [RGB_WIDTH-1:0] MOVEMENT_ZONE_END_COLOR = 8'h80,
    parameter logic [RGB_WIDTH-1:0] PLAYER_ZONE_END_COLOR   = 8'h10,
    parameter logic [RGB_WIDTH-1:0] STATISTICS_ZONE_COLOR   = 8'h02,
    parameter logic [RGB_WIDTH-1:0] STAR_COLOR              = 8'hFF,
    parameter logic [RGB_WIDTH-1:0] FLASH_COLOR             = 8'hE0,
    parameter int STAR_MASK_BITS         = 6,
    parameter int SCROLL_DIV             = 2,
    parameter int FLASH_FRAMES           = 60,
    parameter int FLASH_PERIOD           = 8
) (
    input  logic clk,
    input  logic resetN,
    scrolling_background_if.slave bus
);
    localparam int FL_W = $clog2(FLASH_FRAMES + 1);
    localparam int PH_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

    localparam logic [PIXEL_WIDTH-1:0] LP_STAT_Y   = PIXEL_WIDTH'(Y_FRAME_SIZE - STATISTICS_ZONE_OFFSET);
    localparam logic [PIXEL_WIDTH-1:0] LP_PLAYER_Y = PIXEL_WIDTH'(PLAYER_ZONE_Y);
    localparam logic [PIXEL_WIDTH-1:0] LP_MOVE_L   = PIXEL_WIDTH'(MOVEMENT_ZONE_OFFSET);
    localparam logic [PIXEL_WIDTH-1:0] LP_MOVE_R   = PIXEL_WIDTH'(X_FRAME_SIZE - MOVEMENT_ZONE_OFFSET);

    typedef enum logic {ST_IDLE = 1'b0, ST_FLASH = 1'b1} flash_state_t;

    flash_state_t         r_flash_state;
    logic [FL_W-1:0]      r_frames_left;
    logic [PH_W-1:0]      r_phase_cnt;
    logic                 r_phase;
    logic                 r_flash_active;
    logic [RGB_WIDTH-1:0] r_rgb;
    logic [1:0]           r_draw;

    logic                 w_stat_line;
    logic                 w_player_line;
    logic                 w_move_border;
    logic                 w_star;
    logic [RGB_WIDTH-1:0] w_rgb;

    assign w_stat_line   = (bus.pixelY == LP_STAT_Y);
    assign w_player_line = (bus.pixelY == LP_PLAYER_Y);
    assign w_move_border = (bus.pixelX == LP_MOVE_L) || (bus.pixelX == LP_MOVE_R);

`ifdef BACKGROUND_STARFIELD_EN
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [PIXEL_WIDTH-1:0] r_scroll_offset;
    logic [DIV_W-1:0]       r_scroll_div;
    logic [PIXEL_WIDTH:0]   w_ys_sum;
    logic [PIXEL_WIDTH:0]   w_ys;
    logic [7:0]             w_hx;
    logic [7:0]             w_hy;
    logic [7:0]             w_hash;
    logic                   w_unused_ys;

    // Scroll: every SCROLL_DIV enabled frames the field shifts down one line
    // (offset decrements, wrapping 0 -> last visible line).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_scroll_offset <= '0;
            r_scroll_div    <= '0;
        end else if (bus.startOfFrame && bus.scroll_enable) begin
            if (r_scroll_div == DIV_W'(SCROLL_DIV - 1)) begin
                r_scroll_div    <= '0;
                r_scroll_offset <= (r_scroll_offset == '0) ? PIXEL_WIDTH'(Y_FRAME_SIZE)
                                                           : r_scroll_offset - 1'b1;
            end else begin
                r_scroll_div <= r_scroll_div + 1'b1;
            end
        end
    end

    // Star hash on the scrolled line, restricted to the play field interior.
    assign w_ys_sum = {1'b0, bus.pixelY} + {1'b0, r_scroll_offset};
    assign w_ys     = (w_ys_sum > (PIXEL_WIDTH+1)'(Y_FRAME_SIZE))
                    ? w_ys_sum - (PIXEL_WIDTH+1)'(Y_FRAME_SIZE + 1) : w_ys_sum;
    assign w_hx     = bus.pixelX[7:0] * 8'd37;
    assign w_hy     = w_ys[7:0] * 8'd101;
    assign w_hash   = w_hx ^ w_hy;
    assign w_star   = (w_hash[STAR_MASK_BITS-1:0] == '0) && (bus.pixelY < LP_STAT_Y) &&
                      (bus.pixelX > LP_MOVE_L) && (bus.pixelX < LP_MOVE_R);
    assign w_unused_ys = ^w_ys[PIXEL_WIDTH:8];
    assign bus.dbg_scroll_offset = r_scroll_offset;
`else
    logic w_unused_scroll;

    assign w_star          = 1'b0;
    assign w_unused_scroll = bus.scroll_enable;
    assign bus.dbg_scroll_offset = '0;
`endif

    // Colour priority: statistics line, player line, movement border, star.
    always_comb begin
        w_rgb = BACKGROUND_COLOR;
        if (w_stat_line)
            w_rgb = STATISTICS_ZONE_COLOR;
        else if (w_player_line)
            w_rgb = PLAYER_ZONE_END_COLOR;
        else if (w_move_border)
            w_rgb = r_phase ? FLASH_COLOR : MOVEMENT_ZONE_END_COLOR;
        else if (w_star)
            w_rgb = STAR_COLOR;
    end

    // Output register: colour plus geometry-only border flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rgb  <= BACKGROUND_COLOR;
            r_draw <= 2'b00;
        end else begin
            r_rgb  <= w_rgb;
            r_draw <= {w_player_line, w_move_border};
        end
    end

    // Flash FSM: a trigger (re)loads the sequence and wins over a coincident
    // frame pulse; each frame in FLASH counts down and steps the phase timer.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flash_state  <= ST_IDLE;
            r_frames_left  <= '0;
            r_phase_cnt    <= '0;
            r_phase        <= 1'b0;
            r_flash_active <= 1'b0;
        end else if (bus.flash_trigger) begin
            r_flash_state  <= ST_FLASH;
            r_frames_left  <= FL_W'(FLASH_FRAMES);
            r_phase_cnt    <= '0;
            r_phase        <= 1'b1;
            r_flash_active <= 1'b1;
        end else if ((r_flash_state == ST_FLASH) && bus.startOfFrame) begin
            if (r_frames_left == FL_W'(1)) begin
                r_flash_state  <= ST_IDLE;
                r_frames_left  <= '0;
                r_phase_cnt    <= '0;
                r_phase        <= 1'b0;
                r_flash_active <= 1'b0;
            end else begin
                r_frames_left <= r_frames_left - 1'b1;
                if (r_phase_cnt == PH_W'(FLASH_PERIOD - 1)) begin
                    r_phase_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_phase_cnt <= r_phase_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.background_RGB  = r_rgb;
    assign bus.boardersDrawReq = r_draw;
    assign bus.flash_active    = r_flash_active;
    assign bus.dbg_flash_state = (r_flash_state == ST_FLASH);
endmodule
